// File: rtl/fetch_decode.sv
// IF/ID pipeline stage: latches the fetched word, resolves BR/BEQZ in ID and
// drives redirect/freeze controls back to fetch, with a sticky HALT.
module fetch_decode #(
  parameter int IW = 9,
  parameter int PW = 8
) (
  input  logic          CLK,
  input  logic          Init,
  input  logic [PW-1:0] PC,
  input  logic [IW-1:0] InstIn,
  input  logic          Zero,
  input  logic          Stall,
  output logic          Branch,
  output logic [PW-1:0] Target,
  output logic          Halt,
  output logic          ValidOut,
  output logic [3:0]    OpcodeOut,
  output logic [4:0]    OperandOut,
  output logic [PW-1:0] PCOut,
  output logic          Done
);

  localparam logic [3:0] OP_BR   = 4'hD;
  localparam logic [3:0] OP_BEQZ = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [IW-1:0] ir;
  logic [PW-1:0] ir_pc;
  logic          ir_valid;
  logic          halted;

  logic [3:0]    opcode;
  logic [4:0]    operand;
  logic [PW-1:0] off;
  logic          halt_id;
  logic          take;

  assign opcode  = ir[IW-1 -: 4];
  assign operand = ir[4:0];
  assign off     = {{(PW-5){operand[4]}}, operand};

  assign halt_id = ir_valid & (opcode == OP_HALT);
  assign take    = ir_valid & ~Stall & ~halted &
                   ((opcode == OP_BR) | ((opcode == OP_BEQZ) & Zero));

  // Fetch adds PC+1 itself while sitting at IRPC+1, so the offset is pre-decremented.
  assign Branch     = ~Init & take;
  assign Target     = Init ? {PW{1'b1}} : off - {{(PW-1){1'b0}}, 1'b1};
  assign Halt       = ~Init & (Stall | halted | halt_id);
  assign ValidOut   = ~Init & ir_valid & ~Stall & ~halted;
  assign OpcodeOut  = opcode;
  assign OperandOut = operand;
  assign PCOut      = Init ? {PW{1'b0}} : ir_pc;
  assign Done       = ~Init & halted;

  always_ff @(posedge CLK) begin
    if (Init) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (halted) begin
      ir_valid <= 1'b0;
    end else if (Stall) begin
      ir       <= ir;
      ir_pc    <= ir_pc;
      ir_valid <= ir_valid;
    end else if (halt_id) begin
      halted   <= 1'b1;
      ir_valid <= 1'b0;
    end else if (take) begin
      // The word fetched at IRPC+1 is on the wrong path; capture it as a bubble.
      ir       <= InstIn;
      ir_pc    <= PC;
      ir_valid <= 1'b0;
    end else begin
      ir       <= InstIn;
      ir_pc    <= PC;
      ir_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: a fetch-stage model closes the loop, and an
// instruction-level program model predicts every cycle's outputs.
module tb_fetch_decode;

  logic       CLK = 1'b0;
  logic       Init, Zero, Stall;
  logic [7:0] PC;
  logic [8:0] InstIn;
  logic       Branch, Halt, ValidOut, Done;
  logic [7:0] Target, PCOut;
  logic [3:0] OpcodeOut;
  logic [4:0] OperandOut;

  fetch_decode #(.IW(9), .PW(8)) dut (
    .CLK(CLK), .Init(Init), .PC(PC), .InstIn(InstIn), .Zero(Zero), .Stall(Stall),
    .Branch(Branch), .Target(Target), .Halt(Halt), .ValidOut(ValidOut),
    .OpcodeOut(OpcodeOut), .OperandOut(OperandOut), .PCOut(PCOut), .Done(Done)
  );

  always #5 CLK = ~CLK;

  logic [8:0] imem [256];
  int tests = 0;
  int fails = 0;

  // program-level model state
  logic [7:0] m_pc;
  int         m_bubble;
  logic       m_done;
  logic       prev_init = 1'b0;
  int         n = 0;

  int log_pc [64];
  int log_valid [64];
  int log_br [64];
  int log_tgt [64];
  int log_halt [64];
  int log_done [64];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_imem();
    for (int i = 0; i < 256; i++) imem[i] = {4'(i % 12), 5'(i)};
  endtask

  task automatic tick(input logic i, input logic s, input logic z);
    logic [7:0] nxt;
    logic [8:0] w;
    logic [7:0] off;
    logic [7:0] etgt;
    logic       e_valid, e_branch, e_halt, e_done;
    Init = i; Stall = s; Zero = z; InstIn = imem[PC];
    @(negedge CLK);
    if (i) begin
      chk("init_branch", int'(Branch), 0);
      chk("init_halt", int'(Halt), 0);
      chk("init_valid", int'(ValidOut), 0);
      if (prev_init) begin
        chk("init_done", int'(Done), 0);
        chk("init_target", int'(Target), 'hFF);
        chk("init_pcout", int'(PCOut), 0);
      end
      m_pc = 8'd0; m_bubble = 1; m_done = 1'b0; n = 0;
      nxt = 8'd0;
    end else begin
      e_done = m_done; e_valid = 1'b0; e_branch = 1'b0; e_halt = 1'b0;
      if (m_done || s) begin
        e_halt = 1'b1;
      end else if (m_bubble > 0) begin
        m_bubble--;
      end else begin
        e_valid = 1'b1;
        w = imem[m_pc];
        chk("pcout", int'(PCOut), int'(m_pc));
        chk("opcode", int'(OpcodeOut), int'(w[8:5]));
        chk("operand", int'(OperandOut), int'(w[4:0]));
        off = {{3{w[4]}}, w[4:0]};
        if (w[8:5] == 4'hD || (w[8:5] == 4'hE && z)) begin
          e_branch = 1'b1;
          etgt = off - 8'd1;
          chk("target", int'(Target), int'(etgt));
          m_pc = m_pc + 8'd1 + off;
          m_bubble = 1;
        end else if (w[8:5] == 4'hF) begin
          e_halt = 1'b1;
          m_done = 1'b1;
        end else begin
          m_pc = m_pc + 8'd1;
        end
      end
      chk("valid", int'(ValidOut), int'(e_valid));
      chk("branch", int'(Branch), int'(e_branch));
      chk("halt", int'(Halt), int'(e_halt));
      chk("done", int'(Done), int'(e_done));
      if (n < 64) begin
        log_pc[n] = int'(PCOut); log_valid[n] = int'(ValidOut);
        log_br[n] = int'(Branch); log_tgt[n] = int'(Target);
        log_halt[n] = int'(Halt); log_done[n] = int'(Done);
      end
      n++;
      nxt = Halt ? PC : (Branch ? Target + PC + 8'd1 : PC + 8'd1);
    end
    prev_init = i;
    @(posedge CLK);
    #1 PC = nxt;
  endtask

  task automatic do_init();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run(input int cycles, input logic [31:0] stall_mask, input logic z);
    for (int k = 0; k < cycles; k++) tick(1'b0, stall_mask[k], z);
  endtask

  initial begin
    Init = 1'b1; Stall = 1'b0; Zero = 1'b0; PC = 8'd0; InstIn = 9'd0;
    m_pc = 8'd0; m_bubble = 1; m_done = 1'b0;
    @(posedge CLK); #1;

    // straight-line then BR +3 at 0x04
    fill_imem();
    imem[4] = {4'hD, 5'b00011};
    do_init();
    run(10, 0, 1'b0);
    chk("sl_first_bubble", log_valid[0], 0);
    for (int k = 1; k <= 4; k++) begin
      chk("sl_valid", log_valid[k], 1);
      chk("sl_pc", log_pc[k], k - 1);
    end
    chk("br_taken", log_br[5], 1);
    chk("br_target", log_tgt[5], 'h02);
    chk("br_bubble", log_valid[6], 0);
    chk("br_dest", log_pc[7], 'h08);

    // BEQZ -2 at 0x10, reached by BR +15 from 0x00
    fill_imem();
    imem[0]  = {4'hD, 5'b01111};
    imem[16] = {4'hE, 5'b11110};
    do_init();
    run(6, 0, 1'b0);
    chk("beqz_nt_entry_tgt", log_tgt[1], 'h0E);
    chk("beqz_nt_pc", log_pc[3], 'h10);
    chk("beqz_nt_branch", log_br[3], 0);
    chk("beqz_nt_next", log_pc[4], 'h11);
    chk("beqz_nt_next_valid", log_valid[4], 1);
    do_init();
    run(8, 0, 1'b1);
    chk("beqz_t_branch", log_br[3], 1);
    chk("beqz_t_target", log_tgt[3], 'hFD);
    chk("beqz_t_bubble", log_valid[4], 0);
    chk("beqz_t_dest", log_pc[5], 'h0F);

    // BR held under a 3-cycle stall
    fill_imem();
    imem[0] = {4'hD, 5'b00011};
    do_init();
    run(8, 32'b1110, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      chk("stall_branch", log_br[k], 0);
      chk("stall_halt", log_halt[k], 1);
      chk("stall_ir_held", log_pc[k], 0);
    end
    chk("stall_release_branch", log_br[4], 1);
    chk("stall_single_branch", log_br[5], 0);
    chk("stall_dest", log_pc[6], 'h04);

    // HALT at 0x06, then Init while halted
    fill_imem();
    imem[6] = {4'hF, 5'b00000};
    do_init();
    run(12, 0, 1'b0);
    chk("halt_pc", log_pc[7], 'h06);
    chk("halt_valid", log_valid[7], 1);
    chk("halt_id_halt", log_halt[7], 1);
    chk("halt_done_late", log_done[7], 0);
    chk("halt_done", log_done[8], 1);
    chk("halt_frozen_valid", log_valid[11], 0);
    chk("halt_fetch_pc", int'(PC), 'h07);
    do_init();
    run(3, 0, 1'b0);
    chk("restart_pc", log_pc[1], 0);
    chk("restart_done", log_done[1], 0);

    // HALT in ID under stall: not sticky until stall drops
    do_init();
    run(12, 32'h180, 1'b0);
    chk("haltst_halt", log_halt[7], 1);
    chk("haltst_done", log_done[8], 0);
    chk("haltst_pc", log_pc[9], 'h06);
    chk("haltst_done_after", log_done[10], 1);
    chk("haltst_fetch_pc", int'(PC), 'h07);

    // wrap: 0x00 -> 0xFF, then BR +1 at 0xFF -> 0x01
    fill_imem();
    imem[0]   = {4'hD, 5'b11110};
    imem[255] = {4'hD, 5'b00001};
    do_init();
    run(7, 0, 1'b0);
    chk("wrap_tgt0", log_tgt[1], 'hFD);
    chk("wrap_pc_ff", log_pc[3], 'hFF);
    chk("wrap_target", log_tgt[3], 'h00);
    chk("wrap_dest", log_pc[5], 'h01);

    // self-loop BR -1 at 0x00, then Init while the BR sits in ID
    fill_imem();
    imem[0] = {4'hD, 5'b11111};
    do_init();
    run(4, 0, 1'b0);
    chk("self_target", log_tgt[1], 'hFE);
    chk("self_again", log_pc[3], 0);
    chk("self_again_br", log_br[3], 1);
    do_init();
    run(2, 0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    run(3, 0, 1'b0);
    chk("mid_init_restart", log_pc[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

IF/ID pipeline stage that consumes the 8-bit program counter and the instruction word fetched at that PC. It registers both into an IF/ID register, decodes the control-flow opcodes, and resolves branches in ID. It drives the Branch/Target/Halt controls back to the fetch stage and presents the decoded instruction to execute. It also handles the one-cycle branch flush, downstream stalls and the sticky HALT.

## Interface
- IW, 9, instruction width
- PW, 8, PC width (must match fetch stage)
- CLK  in  1  clock; all state updates on posedge
- Init  in  1  synchronous active-high reset
- PC  in  PW  current fetch-stage PC
- InstIn  in  IW  instruction memory word at PC (combinational lookup, same cycle)
- Zero  in  1  zero flag from execute, sampled combinationally while a BEQZ is in ID
- Stall  in  1  downstream hold request
- Branch  out  1  redirect fetch stage this cycle
- Target  out  PW  offset consumed by fetch as next PC = Target + PC + 1
- Halt  out  1  freeze fetch PC
- ValidOut  out  1  ID instruction valid to execute
- OpcodeOut  out  4  IR[8:5]
- OperandOut  out  5  IR[4:0]
- PCOut  out  PW  PC of the ID instruction
- Done  out  1  processor halted (sticky)

## Operation
- Instruction format: opcode = IR[8:5], operand = IR[4:0].
- Opcodes:
  - 4'hD BR: unconditional branch.
  - 4'hE BEQZ: branch if Zero.
  - 4'hF HALT.
  - All other opcodes pass through to execute with no action here.
- State: IR (IW), IRPC (PW), IRValid, Halted.
- Branch offset: off = sign-extend(IR[4:0]) to PW bits. Destination = IRPC + 1 + off, mod 2^PW.
- When Branch is asserted, the fetch stage PC equals IRPC + 1. Target = off − 1 (mod 2^PW), so fetch computes the correct destination.
- Branch = IRValid & ~Stall & ~Halted & (BR | (BEQZ & Zero)). Branch and Target are combinational from IR and Zero.
- haltID = IRValid & (opcode == HALT).
- Halt = ~Init & (Stall | Halted | haltID).
- Edge update priority:
  1. Init: IR=0, IRPC=0, IRValid=0, Halted=0.
  2. Halted: hold all state, IRValid=0.
  3. Stall: hold IR, IRPC and IRValid.
  4. haltID: Halted<=1, IRValid<=0.
  5. Branch: IR<=InstIn, IRPC<=PC, IRValid<=0 (flush the BrPC+1 fetch).
  6. Otherwise: IR<=InstIn, IRPC<=PC, IRValid<=1.
- ValidOut = IRValid & ~Stall & ~Halted. OpcodeOut, OperandOut and PCOut come straight from IR/IRPC.
- Done = Halted.
- HALT reaches execute as a valid instruction for one cycle (ValidOut=1 while haltID). Execute treats it as a no-op.

## Timing
- Reset values during and after Init: Branch=0, Target=0xFF (off 0 − 1), Halt=0, ValidOut=0, Done=0, PCOut=0.
- First valid instruction: Init deasserts at edge k. Fetch PC=0 in cycle k+1. IR captures imem[0] at edge k+2, so ValidOut=1 in cycle k+2.
- Fetch-to-ID latency is 1 cycle. Taken branch costs exactly 1 bubble. Not-taken BEQZ costs 0.
- Stall: IR is held, and Branch/ValidOut are suppressed for as long as Stall is high. Halt=1 also freezes fetch. A branch held under Stall resolves in the first cycle Stall is low, using Zero in that cycle.
- HALT in ID: Halt=1 combinationally in that cycle. Fetch PC freezes at HALT_PC+1. Done=1 from the next cycle until Init.
- HALT in ID under Stall: Halt=1, Halted is not set until Stall drops.
- Wrap-around: IRPC=0xFF with off=+1 gives destination 0x01. off=−1 from PC 0x00 gives destination 0x00.
- Init mid-branch or while halted: the reset takes effect at that edge, and no Branch is asserted in the Init cycle.

## Test plan
- Reset then straight-line: imem[0..3] = ALU ops, no stall -> ValidOut rises 2 cycles after Init falls; PCOut steps 0,1,2,3 on consecutive cycles.
- BR with operand 5'b00011 at PC 0x04 -> Branch=1 and Target=0x02 in the ID cycle; the next cycle shows ValidOut=0 (bubble); the following cycle shows PCOut=0x08.
- BEQZ with operand 5'b11110 (−2) at PC 0x10: with Zero=0, no Branch and PCOut=0x11 next cycle; with Zero=1, Target=0xFD and the instruction after the bubble has PCOut=0x0F.
- Stall held 3 cycles while BR is in ID -> Branch=0, Halt=1, IR held for 3 cycles; on Stall release Branch=1 for exactly 1 cycle.
- HALT at PC 0x06 -> Halt=1 in the ID cycle, Done=1 from the next cycle, fetch PC stays 0x07, ValidOut=0 forever; Init then restarts from PC 0.
- Wrap: BR with operand +1 at PC 0xFF -> Target=0x00, next valid PCOut=0x01.
